// File: rtl/imm_extend_unit.sv
// Immediate extension unit: zero/sign/branch-shift/upper extension of an IN_W immediate to OUT_W.
// Latency: 1 cycle from input fire to out_data when the output register is free.
// Backpressure: a 2-entry output/skid pair keeps in_ready registered; in_ready drops only when both are full.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous flush; drops every held entry, wins over all other events
//   in_valid/in_ready     input handshake; in_ready depends on registered state only
//   in_imm, in_mode       raw immediate and extension mode (00 zext, 01 sext, 10 sext<<SHIFT, 11 upper)
//   in_tag                sideband tag carried alongside the result
//   out_valid/out_ready   output handshake; out_data/out_tag hold steady while stalled
//   out_data, out_tag     extended operand and its tag
//   xfer_cnt, stall_cnt   only with IMMX_PERF_CNT_EN defined: output fires and stalled-output cycles
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMX_PERF_CNT_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  // Parameter legality is checked at elaboration.
  if (IN_W + SHIFT > OUT_W) begin : g_bad_width
    $error("imm_extend_unit: IN_W + SHIFT must not exceed OUT_W");
  end
  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_unit: IN_W must be at least 2");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic [OUT_W-1:0] ext_data;
  logic             in_fire;
  logic             out_fire;

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Extension on the input side so both destination registers load a finished value.
  always_comb begin
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;
    zext               = '0;
    zext[IN_W-1:0]     = in_imm;
    sext               = {OUT_W{in_imm[IN_W-1]}};
    sext[IN_W-1:0]     = in_imm;
    upper              = '0;
    upper[OUT_W-1 -: IN_W] = in_imm;
    ext_data           = zext;
    case (in_mode)
      2'b00:   ext_data = zext;
      2'b01:   ext_data = sext;
      2'b10:   ext_data = sext << SHIFT;
      2'b11:   ext_data = upper;
      default: ext_data = zext;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is dropped.
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_data <= ext_data;
            out_tag  <= in_tag;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_data <= ext_data;
            out_tag  <= in_tag;
          end else if (in_fire) begin
            // Output is stalled: park the newcomer behind it.
            skid_data <= ext_data;
            skid_tag  <= in_tag;
            state     <= ST_FULL;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            out_data <= skid_data;
            out_tag  <= skid_tag;
            state    <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef IMMX_PERF_CNT_EN
  // Counters survive flush; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_fire) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef IMMX_PERF_CNT_EN
  logic [31:0] xfer_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t        sb[$];
  logic [4:0]  seen_tags[$];
  logic        last_in_fire = 1'b0;

  imm_extend_unit #(.IN_W(16), .OUT_W(32), .SHIFT(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef IMMX_PERF_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference extension for the default 16 -> 32, shift 2 configuration.
  function automatic logic [31:0] exp_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = $signed(imm);
    case (mode)
      2'b00:   return {16'h0000, imm};
      2'b01:   return s;
      2'b10:   return s * 4;
      default: return {imm, 16'h0000};
    endcase
  endfunction

  // Scoreboard: samples 1 ns before each rising edge, after all stimulus has settled.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      sb.delete();
      last_in_fire = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        seen_tags.push_back(out_tag);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got tag %0d data %h, required no output", out_tag, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL sb_compare: got tag %0d data %h, required tag %0d data %h",
                     out_tag, out_data, e.tag, e.data);
          end
        end
      end
      last_in_fire = in_valid && in_ready && !flush;
      if (last_in_fire) sb.push_back('{data: exp_ext(in_imm, in_mode), tag: in_tag});
      if (flush) sb.delete();
    end
  end

  task automatic send(input logic [4:0] tag, input logic [15:0] imm, input logic [1:0] mode);
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = tag; in_imm = imm; in_mode = mode;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = last_in_fire;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: tag %0d not accepted, got in_ready=%b, required 1", tag, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b d=%h t=%0d, required v=0 r=1 d=0 t=0",
               out_valid, in_ready, out_data, out_tag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_modes;
    logic [15:0] imms[5]  = '{16'h8002, 16'h8002, 16'h8002, 16'h536A, 16'h536A};
    logic [1:0]  modes[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [31:0] exps[5]  = '{32'hFFFF8002, 32'h00008002, 32'hFFFE0008, 32'h536A0000, 32'h0000536A};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 5'(i + 10);
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i] || out_tag !== 5'(i + 10)) begin
        n_fail++;
        $display("FAIL mode_%0d: got v=%b d=%h t=%0d, required v=1 d=%h t=%0d",
                 i, out_valid, out_data, out_tag, exps[i], i + 10);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit done = 1'b0;
    out_ready = 1'b0;
    seen_tags.delete();
    @(negedge clk);
    in_valid = 1'b1; in_tag = 5'd1; in_imm = 16'h0011; in_mode = 2'b00;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_one: got r=%b v=%b, required r=1 v=1", in_ready, out_valid);
    end
    in_tag = 5'd2; in_imm = 16'hFF22; in_mode = 2'b01;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b, required 0", in_ready);
    end
    in_tag = 5'd3; in_imm = 16'h0033; in_mode = 2'b10;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_data !== 32'h00000011) begin
      n_fail++;
      $display("FAIL bp_hold: got r=%b t=%0d d=%h, required r=0 t=1 d=00000011",
               in_ready, out_tag, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (last_in_fire) in_valid = 1'b0;
      done = (seen_tags.size() >= 3);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seen_tags.size() != 3 || seen_tags[0] !== 5'd1 || seen_tags[1] !== 5'd2 || seen_tags[2] !== 5'd3) begin
      n_fail++;
      $display("FAIL bp_order: got %0d outputs %p, required tags 1,2,3", seen_tags.size(), seen_tags);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = 5'd4; in_imm = 16'h0004; in_mode = 2'b00;
    @(negedge clk);
    in_tag = 5'd5; in_imm = 16'h0005;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_prefull: got in_ready=%b, required 0", in_ready);
    end
    flush = 1'b1; in_tag = 5'd6; in_imm = 16'h0006;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
    end
    seen_tags.delete();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (seen_tags.size() != 0) begin
      n_fail++;
      $display("FAIL flush_leak: got %0d outputs %p, required none", seen_tags.size(), seen_tags);
    end
    send(5'd7, 16'h7007, 2'b11);
    repeat (2) @(negedge clk);
    n_checks++;
    if (seen_tags.size() != 1 || seen_tags[0] !== 5'd7) begin
      n_fail++;
      $display("FAIL flush_after: got outputs %p, required tag 7 only", seen_tags);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = 5'd8; in_imm = 16'h0008; in_mode = 2'b01;
    @(negedge clk);
    in_tag = 5'd9;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    seen_tags.delete();
    out_ready = 1'b1;
    send(5'd10, 16'hA00A, 2'b10);
    repeat (2) @(negedge clk);
    n_checks++;
    if (seen_tags.size() != 1 || seen_tags[0] !== 5'd10) begin
      n_fail++;
      $display("FAIL rst_first: got outputs %p, required tag 10 only", seen_tags);
    end
  endtask

  task automatic test_back_to_back;
    bit done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!in_valid || last_in_fire) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_imm   = 16'($urandom);
        in_mode  = 2'($urandom_range(0, 3));
        in_tag   = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !in_valid || last_in_fire;
    end
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0 && !out_valid);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, out_valid=%b, required 0 pending", sb.size(), out_valid);
    end
  endtask

`ifdef IMMX_PERF_CNT_EN
  task automatic test_perf;
    logic [31:0] x0, s0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_tag = 5'(i); in_imm = 16'(i * 3); in_mode = 2'(i);
      out_ready = (i >= 4);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 4) begin
        @(negedge clk);
        out_ready = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (xfer_cnt !== 32'd10 || stall_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_counts: got xfer=%0d stall=%0d, required xfer=10 stall=4", xfer_cnt, stall_cnt);
    end
    x0 = xfer_cnt; s0 = stall_cnt;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (xfer_cnt !== x0 || stall_cnt !== s0) begin
      n_fail++;
      $display("FAIL perf_flush: got xfer=%0d stall=%0d, required xfer=%0d stall=%0d",
               xfer_cnt, stall_cnt, x0, s0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef IMMX_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
